// File: rtl/branch_predictor_pkg.sv
// branch_pred_pkg: definitions shared by the branch predictor and its
// counter sub-module.
//   ctr_t       2-bit saturating branch-direction counter
//   CTR_*       counter states, strong-not-taken .. strong-taken
//   CTR_RESET   counter value every entry holds after reset
//   CTR_ALLOC   counter value a newly allocated entry starts with
package branch_pred_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: groups the fetch-side lookup signals and the
// EX-side update signals of the branch predictor.
//   pc             fetch PC to predict for
//   branch_taken   prediction: take the branch at pc
//   branch_target  predicted next PC
//   predict_hit    pc hit a valid BTB entry
//   update_valid   a conditional branch resolved this cycle
//   update_pc      PC of the resolved branch
//   update_taken   actual outcome
//   update_target  actual target
// master: the fetch/EX side driving lookups and updates.
// slave:  the predictor.
interface branch_predictor_if;

  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        predict_hit;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  modport master (
    output pc,
    output update_valid,
    output update_pc,
    output update_taken,
    output update_target,
    input  branch_taken,
    input  branch_target,
    input  predict_hit
  );

  modport slave (
    input  pc,
    input  update_valid,
    input  update_pc,
    input  update_taken,
    input  update_target,
    output branch_taken,
    output branch_target,
    output predict_hit
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state logic of a 2-bit saturating direction counter.
//   ctr       current counter value
//   taken     resolved branch outcome
//   ctr_next  counter moved one step toward taken (increment) or
//             not-taken (decrement), holding at 11 and 00
module sat_counter2
  import branch_pred_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    ctr_t r;
    r = c;
    if (up) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

  assign ctr_next = sat_step(ctr, taken);

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage dynamic branch predictor. A direct-mapped
// BTB of ENTRIES entries (valid, tag, target, 2-bit counter) is looked up
// combinationally with the fetch PC; resolved branches write back through
// the update port on the rising clock edge.
//   clk    clock; all state updates on its rising edge
//   reset  asynchronous active-high reset; clears every entry
//   bp     branch_predictor_if slave: lookup (pc -> branch_taken,
//          branch_target, predict_hit) and update (update_*) signals
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);

  localparam int TAG_W = 30 - IDX_W;

  // Flop storage: reset must clear every entry and the read is combinational.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic             rd_taken;

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  ctr_t             ctr_upd;

  // Byte offset within the instruction word plays no part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc[1:0], bp.update_pc[1:0]};

  // Lookup: index decode, tag compare, target mux.
  assign rd_idx   = bp.pc[IDX_W+1:2];
  assign rd_tag   = bp.pc[31:IDX_W+2];
  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken = rd_hit && ctr_q[rd_idx][1];

  assign bp.predict_hit   = rd_hit;
  assign bp.branch_taken  = rd_taken;
  assign bp.branch_target = rd_taken ? target_q[rd_idx] : (bp.pc + 32'd4);

  // Update side: the entry addressed by update_pc.
  assign wr_idx = bp.update_pc[IDX_W+1:2];
  assign wr_tag = bp.update_pc[31:IDX_W+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[wr_idx]),
    .taken    (bp.update_taken),
    .ctr_next (ctr_upd)
  );

  // Reads see the pre-update contents in the update cycle; no bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (bp.update_valid) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_upd;
        if (bp.update_taken) target_q[wr_idx] <= bp.update_target;
      end else if (bp.update_taken) begin
        // Allocate, overwriting whatever occupied this index.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= bp.update_target;
        ctr_q[wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd_v;
    logic [31:0] upd_pc;
    logic        upd_t;
    logic [31:0] upd_tg;
    logic [31:0] pc;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic h, input logic t,
                       input logic [31:0] tg);
    n_checks++;
    if (bus.predict_hit !== h) begin
      n_fail++;
      $display("FAIL %s predict_hit: got %b expected %b", nm, bus.predict_hit, h);
    end
    n_checks++;
    if (bus.branch_taken !== t) begin
      n_fail++;
      $display("FAIL %s branch_taken: got %b expected %b", nm, bus.branch_taken, t);
    end
    n_checks++;
    if (bus.branch_target !== tg) begin
      n_fail++;
      $display("FAIL %s branch_target: got %h expected %h", nm, bus.branch_target, tg);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // ENTRIES=16: index = pc[5:2], tag = pc[31:6].
    // 0x100, 0x140, 0x200 share index 0; 0x144 is index 1.
    //            upd_v  upd_pc        upd_t upd_tg        pc            hit   tk    tgt
    vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104};
    vecs[1]  = '{1'b1, 32'h0000_0200, 1'b0, 32'h0000_0300, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0204};
    vecs[2]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0080, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0080};
    vecs[3]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0140, 1'b0, 1'b0, 32'h0000_0144};
    vecs[4]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h000D_EAD0, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
    vecs[5]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
    vecs[6]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
    vecs[7]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0090, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
    vecs[8]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0090, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0090};
    vecs[9]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_00A0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_00A0};
    vecs[10] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_00A0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_00A0};
    vecs[11] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0555, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_00A0};
    vecs[12] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0104};
    vecs[13] = '{1'b1, 32'h0000_0140, 1'b1, 32'h0000_0300, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104};
    vecs[14] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0140, 1'b1, 1'b1, 32'h0000_0300};
    vecs[15] = '{1'b1, 32'h0000_0144, 1'b1, 32'h0000_0400, 32'h0000_0144, 1'b1, 1'b1, 32'h0000_0400};
    vecs[16] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000};
    vecs[17] = '{1'b0, 32'h0000_0144, 1'b0, 32'h0000_0777, 32'h0000_0144, 1'b1, 1'b1, 32'h0000_0400};
    vecs[18] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0147, 1'b1, 1'b1, 32'h0000_0400};

    reset             = 1'b1;
    bus.pc            = 32'h0000_0100;
    bus.update_valid  = 1'b0;
    bus.update_pc     = '0;
    bus.update_taken  = 1'b0;
    bus.update_target = '0;

    repeat (2) @(negedge clk);
    check("reset_state", 1'b0, 1'b0, 32'h0000_0104);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.update_valid  = vecs[i].upd_v;
      bus.update_pc     = vecs[i].upd_pc;
      bus.update_taken  = vecs[i].upd_t;
      bus.update_target = vecs[i].upd_tg;
      bus.pc            = vecs[i].pc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].hit, vecs[i].tk, vecs[i].tgt);
    end

    // Mid-stream reset takes effect without a clock edge.
    @(negedge clk);
    bus.update_valid = 1'b0;
    bus.pc           = 32'h0000_0140;
    #1;
    check("pre_midreset", 1'b1, 1'b1, 32'h0000_0300);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_0x140", 1'b0, 1'b0, 32'h0000_0144);
    bus.pc = 32'h0000_0144;
    #1;
    check("midreset_0x144", 1'b0, 1'b0, 32'h0000_0148);
    bus.pc = 32'hFFFF_FFFC;
    #1;
    check("midreset_wrap", 1'b0, 1'b0, 32'h0000_0000);
    @(negedge clk);
    reset  = 1'b0;
    bus.pc = 32'h0000_0140;
    @(posedge clk);
    #1;
    check("after_midreset", 1'b0, 1'b0, 32'h0000_0144);

    // Same-cycle allocate and lookup: pre-update contents this cycle.
    @(negedge clk);
    bus.update_valid  = 1'b1;
    bus.update_pc     = 32'h0000_0100;
    bus.update_taken  = 1'b1;
    bus.update_target = 32'h0000_0080;
    bus.pc            = 32'h0000_0100;
    #1;
    check("same_cycle_pre", 1'b0, 1'b0, 32'h0000_0104);
    @(posedge clk);
    #1;
    check("same_cycle_post", 1'b1, 1'b1, 32'h0000_0080);

    // Update presented as reset deasserts is applied at the next edge.
    @(negedge clk);
    bus.update_valid = 1'b0;
    reset            = 1'b1;
    @(negedge clk);
    reset             = 1'b0;
    bus.update_valid  = 1'b1;
    bus.update_pc     = 32'h0000_0200;
    bus.update_taken  = 1'b1;
    bus.update_target = 32'h0000_0088;
    bus.pc            = 32'h0000_0200;
    @(posedge clk);
    #1;
    check("update_at_deassert", 1'b1, 1'b1, 32'h0000_0088);
    @(negedge clk);
    bus.update_valid = 1'b0;
    bus.pc           = 32'h0000_0100;
    #1;
    check("cleared_0x100", 1'b0, 1'b0, 32'h0000_0104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
